arf096b192e1r1w0cbbeheaa4acw_gclk_rpen_ctrl: RTL and testbench



---
 rtl/arf096b192e1r1w0cbbeheaa4acw_gclk_pkg.sv | 14 +
 rtl/arf096b192e1r1w0cbbeheaa4acw_gclk_sat_cnt.sv | 29 ++
 rtl/arf096b192e1r1w0cbbeheaa4acw_gclk_rpen_ctrl.sv | 113 +++++++++++
 tb/tb_arf096b192e1r1w0cbbeheaa4acw_gclk_rpen_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/arf096b192e1r1w0cbbeheaa4acw_gclk_pkg.sv
// Shared types and default widths for the regional clock power-enable controller.
package arf096b192e1r1w0cbbeheaa4acw_gclk_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        WAKE  = 2'd1,
        ON    = 2'd2,
        DRAIN = 2'd3
    } pwr_state_t;

    localparam int IDLE_W_DFLT = 6;
    localparam int WAKE_W_DFLT = 3;

endpackage

// File: rtl/arf096b192e1r1w0cbbeheaa4acw_gclk_sat_cnt.sv
// Saturating up/down counter with synchronous clear and load (clear > load > inc > dec).
module arf096b192e1r1w0cbbeheaa4acw_gclk_sat_cnt #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] ldVal,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= ldVal;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

endmodule

// File: rtl/arf096b192e1r1w0cbbeheaa4acw_gclk_rpen_ctrl.sv
// Registered regional power enable (RPEn) generator with warm-up stall and idle hysteresis.
// Also re-times the LCP controls so the RCB only ever sees flop outputs.
//
//   state | meaning
//   OFF   | region clock gated, requesters stalled
//   WAKE  | RPEn high, counting down warm-up, requesters stalled
//   ON    | region clocked, accesses proceed, idle cycles counted
//   DRAIN | one last clocked cycle with AccRdy low before RPEn drops
module arf096b192e1r1w0cbbeheaa4acw_gclk_rpen_ctrl
    import arf096b192e1r1w0cbbeheaa4acw_gclk_pkg::*;
#(
    parameter int IDLE_W   = IDLE_W_DFLT,
    parameter int WAKE_W   = WAKE_W_DFLT,
    parameter     IDLE_RST = 6'd32
) (
    input  logic              CkGridX1N,
    input  logic              Reset,
    input  logic              RdReq,
    input  logic              WrReq,
    output logic              AccRdy,
    input  logic [IDLE_W-1:0] IdleThr,
    input  logic [WAKE_W-1:0] WakeLat,
    input  logic              CfgOvrd,
    input  logic              CfgFd,
    input  logic              CfgRd,
    output logic              RPEn,
    output logic              RPOvrd,
    output logic              Fd,
    output logic              Rd,
    output logic [1:0]        PwrState
);

    if (IDLE_RST >= (1 << IDLE_W)) begin : gIdleRstChk
        $error("IDLE_RST does not fit in IDLE_W bits");
    end

    pwr_state_t        state;
    pwr_state_t        stateNxt;
    logic              req;
    logic              wakeReq;
    logic [IDLE_W-1:0] icnt;
    logic [WAKE_W-1:0] wcnt;
    logic              icntClr;
    logic              icntInc;
    logic              wcntLd;
    logic              wcntDec;

    assign req     = RdReq | WrReq;
    assign wakeReq = req | CfgOvrd;

    always_comb begin
        stateNxt = state;
        unique case (state)
            OFF:   if (wakeReq) stateNxt = WAKE;
            WAKE:  if (wcnt == '0) stateNxt = ON;
            // Pending request or override always wins over the idle exit.
            ON:    if (!wakeReq && (icnt == IdleThr)) stateNxt = DRAIN;
            DRAIN: stateNxt = wakeReq ? ON : OFF;
            default: stateNxt = OFF;
        endcase
    end

    always_comb begin
        icntClr = (state != ON) || wakeReq;
        icntInc = (state == ON);
        wcntLd  = (state == OFF) && wakeReq;
        wcntDec = (state == WAKE);
    end

    arf096b192e1r1w0cbbeheaa4acw_gclk_sat_cnt #(.W(IDLE_W)) uIdleCnt (
        .clk   (CkGridX1N),
        .rst   (Reset),
        .clr   (icntClr),
        .ld    (1'b0),
        .ldVal ('0),
        .inc   (icntInc),
        .dec   (1'b0),
        .cnt   (icnt)
    );

    arf096b192e1r1w0cbbeheaa4acw_gclk_sat_cnt #(.W(WAKE_W)) uWakeCnt (
        .clk   (CkGridX1N),
        .rst   (Reset),
        .clr   (1'b0),
        .ld    (wcntLd),
        .ldVal (WakeLat),
        .inc   (1'b0),
        .dec   (wcntDec),
        .cnt   (wcnt)
    );

    // Outputs are decoded from the next state so they change on the same edge as the FSM.
    always_ff @(posedge CkGridX1N) begin
        if (Reset) begin
            state  <= OFF;
            RPEn   <= 1'b0;
            AccRdy <= 1'b0;
            RPOvrd <= 1'b0;
            Fd     <= 1'b0;
            Rd     <= 1'b0;
        end else begin
            state  <= stateNxt;
            RPEn   <= (stateNxt != OFF);
            AccRdy <= (stateNxt == ON);
            RPOvrd <= CfgOvrd;
            Fd     <= CfgFd;
            Rd     <= CfgRd;
        end
    end

    assign PwrState = state;

endmodule

// File: tb/tb_arf096b192e1r1w0cbbeheaa4acw_gclk_rpen_ctrl.sv
// Directed-vector bench: stimulus pushes expected post-edge outputs, a monitor pops and compares.
module tb_arf096b192e1r1w0cbbeheaa4acw_gclk_rpen_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rdReq = 1'b0;
    logic       wrReq = 1'b0;
    logic       accRdy;
    logic [5:0] idleThr = 6'd4;
    logic [2:0] wakeLat = 3'd3;
    logic       cfgOvrd = 1'b0;
    logic       cfgFd = 1'b0;
    logic       cfgRd = 1'b0;
    logic       rpEn;
    logic       rpOvrd;
    logic       fd;
    logic       rd;
    logic [1:0] pwrState;

    typedef struct {
        string      name;
        logic [6:0] exp;   // {PwrState, RPEn, AccRdy, RPOvrd, Fd, Rd}
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    arf096b192e1r1w0cbbeheaa4acw_gclk_rpen_ctrl dut (
        .CkGridX1N (clk),
        .Reset     (rst),
        .RdReq     (rdReq),
        .WrReq     (wrReq),
        .AccRdy    (accRdy),
        .IdleThr   (idleThr),
        .WakeLat   (wakeLat),
        .CfgOvrd   (cfgOvrd),
        .CfgFd     (cfgFd),
        .CfgRd     (cfgRd),
        .RPEn      (rpEn),
        .RPOvrd    (rpOvrd),
        .Fd        (fd),
        .Rd        (rd),
        .PwrState  (pwrState)
    );

    // Monitor: the DUT presents a fresh output vector after every active edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() != 0) begin
                exp_t e;
                logic [6:0] act;
                e   = expQ.pop_front();
                act = {pwrState, rpEn, accRdy, rpOvrd, fd, rd};
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got st=%0d rpen=%b acc=%b ovrd=%b fd=%b rd=%b, expected st=%0d rpen=%b acc=%b ovrd=%b fd=%b rd=%b",
                             e.name, act[6:5], act[4], act[3], act[2], act[1], act[0],
                             e.exp[6:5], e.exp[4], e.exp[3], e.exp[2], e.exp[1], e.exp[0]);
                end
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic cyc(input string nm, input logic r, input logic rq, input logic wq,
                       input logic ov, input logic f, input logic d,
                       input logic [1:0] st, input logic pe, input logic ar);
        exp_t e;
        @(negedge clk);
        rst = r; rdReq = rq; wrReq = wq; cfgOvrd = ov; cfgFd = f; cfgRd = d;
        e.name = nm;
        e.exp  = {st, pe, ar, (r ? 1'b0 : ov), (r ? 1'b0 : f), (r ? 1'b0 : d)};
        expQ.push_back(e);
    endtask

    initial begin
        // Reset held with a pending read: stays OFF.
        for (int i = 0; i < 3; i++) cyc("reset", 1, 1, 0, 0, 1, 1, 2'd0, 0, 0);

        // WakeLat=3, IdleThr=4, write request held until AccRdy.
        cyc("wake_e1", 0, 0, 1, 0, 0, 0, 2'd1, 1, 0);
        for (int i = 0; i < 3; i++) cyc("wake_cnt", 0, 0, 1, 0, 0, 0, 2'd1, 1, 0);
        cyc("wake_e5_rdy", 0, 0, 1, 0, 0, 0, 2'd2, 1, 1);
        cyc("access", 0, 0, 1, 0, 1, 0, 2'd2, 1, 1);
        for (int i = 0; i < 4; i++) cyc("idle_on", 0, 0, 0, 0, i[0], 0, 2'd2, 1, 1);
        cyc("idle5_drain", 0, 0, 0, 0, 0, 1, 2'd3, 1, 0);
        cyc("drain_off", 0, 0, 0, 0, 1, 1, 2'd0, 0, 0);
        cyc("stay_off", 0, 0, 0, 0, 0, 0, 2'd0, 0, 0);

        // WakeLat=0, IdleThr=0.
        @(negedge clk); wakeLat = 3'd0; idleThr = 6'd0;
        expQ.push_back('{name: "cfg_off", exp: 7'b0000000});
        cyc("z_wake", 0, 1, 0, 0, 1, 0, 2'd1, 1, 0);
        cyc("z_rdy", 0, 1, 0, 0, 0, 1, 2'd2, 1, 1);
        cyc("z_access", 0, 1, 0, 0, 1, 1, 2'd2, 1, 1);
        cyc("z_drain", 0, 0, 0, 0, 0, 0, 2'd3, 1, 0);
        cyc("z_off", 0, 0, 0, 0, 0, 0, 2'd0, 0, 0);

        // Request re-asserted during DRAIN returns straight to ON.
        cyc("d_wake", 0, 1, 0, 0, 0, 0, 2'd1, 1, 0);
        cyc("d_rdy", 0, 1, 0, 0, 0, 0, 2'd2, 1, 1);
        cyc("d_drain", 0, 0, 0, 0, 0, 0, 2'd3, 1, 0);
        cyc("d_reon", 0, 0, 1, 0, 0, 0, 2'd2, 1, 1);
        cyc("d_hold", 0, 0, 1, 0, 0, 0, 2'd2, 1, 1);
        cyc("d_drain2", 0, 0, 0, 0, 0, 0, 2'd3, 1, 0);
        cyc("d_ovrd_in_drain", 0, 0, 0, 1, 0, 0, 2'd2, 1, 1);
        cyc("d_drain3", 0, 0, 0, 0, 0, 0, 2'd3, 1, 0);
        cyc("d_off", 0, 0, 0, 0, 0, 0, 2'd0, 0, 0);

        // Reset mid-ON, then re-arbitrate.
        cyc("r_wake", 0, 1, 0, 0, 0, 0, 2'd1, 1, 0);
        cyc("r_rdy", 0, 1, 0, 0, 0, 0, 2'd2, 1, 1);
        cyc("r_reset", 1, 1, 0, 1, 1, 1, 2'd0, 0, 0);
        cyc("r_rewake", 0, 1, 0, 0, 0, 0, 2'd1, 1, 0);
        cyc("r_on_noreq", 0, 0, 0, 0, 0, 0, 2'd2, 1, 1);
        cyc("r_drain", 0, 0, 0, 0, 0, 0, 2'd3, 1, 0);
        cyc("r_off", 0, 0, 0, 0, 0, 0, 2'd0, 0, 0);

        // Override for 200 cycles, WakeLat=1, IdleThr=4; Fd/Rd toggle throughout.
        @(negedge clk); wakeLat = 3'd1; idleThr = 6'd4;
        expQ.push_back('{name: "cfg_off2", exp: 7'b0000000});
        cyc("o_wake", 0, 0, 0, 1, 1, 0, 2'd1, 1, 0);
        cyc("o_wake_cnt", 0, 0, 0, 1, 0, 1, 2'd1, 1, 0);
        cyc("o_on", 0, 0, 0, 1, 1, 1, 2'd2, 1, 1);
        for (int i = 0; i < 200; i++) cyc("o_hold", 0, 0, 0, 1, i[0], i[1], 2'd2, 1, 1);
        for (int i = 0; i < 4; i++) cyc("o_release_idle", 0, 0, 0, 0, i[1], i[0], 2'd2, 1, 1);
        cyc("o_release_drain", 0, 0, 0, 0, 0, 0, 2'd3, 1, 0);
        cyc("o_release_off", 0, 0, 0, 0, 1, 0, 2'd0, 0, 0);
        cyc("o_fd_off", 0, 0, 0, 0, 0, 1, 2'd0, 0, 0);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain_queue: got %0d pending, expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
